vreg_responder: RTL and testbench

Responder end of the vector register interface. It accepts `cntrl_req_t` read and write requests from each of the `NUM_OF_LANES` pipeline lanes, grants them under per-lane flow control, and holds the lane-private vector register storage. It returns read data on `reg_rsp_vld`/`reg_rsp_data`. It sits beside the single-threaded pipeline and drives that pipeline's `reg_req_grant`, `reg_rsp_vld` and `reg_rsp_data` inputs.

---
 rtl/vreg_responder_pkg.sv | 17 +
 rtl/vreg_lane_bank.sv | 95 +++++++++
 rtl/vreg_responder.sv | 34 +++
 tb/tb_vreg_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vreg_responder_pkg.sv
// Shared types and default sizing for the vector register responder.
package vreg_responder_pkg;

    localparam int NUM_OF_LANES      = 4;
    localparam int VECTOR_REG_WIDTH  = 64;
    localparam int NUM_OF_VECTOR_REG = 32;
    localparam int VREG_ADDR_WIDTH   = $clog2(NUM_OF_VECTOR_REG);

    // One lane's register request as issued by the pipeline.
    typedef struct packed {
        logic                        vld;
        logic                        we;
        logic [VREG_ADDR_WIDTH-1:0]  addr;
        logic [VECTOR_REG_WIDTH-1:0] data;
    } cntrl_req_t;

endpackage

// File: rtl/vreg_lane_bank.sv
// One lane: request FIFO, private register storage and read-response register.
module vreg_lane_bank
    import vreg_responder_pkg::*;
#(
    parameter int VECTOR_REG_WIDTH  = vreg_responder_pkg::VECTOR_REG_WIDTH,
    parameter int NUM_OF_VECTOR_REG = vreg_responder_pkg::NUM_OF_VECTOR_REG,
    parameter int REQ_BUF_DEPTH     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cntrl_req_t                  req,
    output logic                        grant,
    output logic                        rsp_vld,
    output logic [VECTOR_REG_WIDTH-1:0] rsp_data
);

    localparam int PTR_W = (REQ_BUF_DEPTH > 1) ? $clog2(REQ_BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(REQ_BUF_DEPTH + 1);

    logic                        buf_we   [REQ_BUF_DEPTH];
    logic [VREG_ADDR_WIDTH-1:0]  buf_addr [REQ_BUF_DEPTH];
    logic [VECTOR_REG_WIDTH-1:0] buf_data [REQ_BUF_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [VECTOR_REG_WIDTH-1:0] storage [NUM_OF_VECTOR_REG];

    logic                        enq;
    logic                        deq;
    logic                        head_we;
    logic [VREG_ADDR_WIDTH-1:0]  head_addr;
    logic [VECTOR_REG_WIDTH-1:0] head_data;

    // Grant comes only from registered occupancy; a same-cycle dequeue never
    // reopens a full buffer.
    assign grant     = (count < CNT_W'(REQ_BUF_DEPTH));
    assign enq       = req.vld & grant;
    assign deq       = (count != '0);
    assign head_we   = buf_we[rd_ptr];
    assign head_addr = buf_addr[rd_ptr];
    assign head_data = buf_data[rd_ptr];

    // FIFO pointers and occupancy; pointers wrap at the buffer depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= (wr_ptr == PTR_W'(REQ_BUF_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (deq)
                rd_ptr <= (rd_ptr == PTR_W'(REQ_BUF_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer payload; contents are only meaningful behind valid pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            buf_we[wr_ptr]   <= req.we;
            buf_addr[wr_ptr] <= req.addr;
            buf_data[wr_ptr] <= req.data;
        end
    end

    // Register storage: cleared on reset, written when a write reaches the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_OF_VECTOR_REG; r++)
                storage[r] <= '0;
        end else if (deq && head_we) begin
            storage[head_addr] <= head_data;
        end
    end

    // Read response: one-cycle valid pulse, data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld  <= 1'b0;
            rsp_data <= '0;
        end else begin
            rsp_vld <= deq & ~head_we;
            if (deq && !head_we)
                rsp_data <= storage[head_addr];
        end
    end

endmodule

// File: rtl/vreg_responder.sv
// Responder for the vector register interface: one independent bank per lane.
module vreg_responder
    import vreg_responder_pkg::*;
#(
    parameter int NUM_OF_LANES      = vreg_responder_pkg::NUM_OF_LANES,
    parameter int VECTOR_REG_WIDTH  = vreg_responder_pkg::VECTOR_REG_WIDTH,
    parameter int NUM_OF_VECTOR_REG = vreg_responder_pkg::NUM_OF_VECTOR_REG,
    parameter int REQ_BUF_DEPTH     = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  cntrl_req_t [NUM_OF_LANES-1:0]                 reg_req,
    output logic [NUM_OF_LANES-1:0]                       reg_req_grant,
    output logic [NUM_OF_LANES-1:0]                       reg_rsp_vld,
    output logic [NUM_OF_LANES-1:0][VECTOR_REG_WIDTH-1:0] reg_rsp_data
);

    // Lanes share nothing, so the top is pure wiring.
    for (genvar g = 0; g < NUM_OF_LANES; g++) begin : g_lane
        vreg_lane_bank #(
            .VECTOR_REG_WIDTH (VECTOR_REG_WIDTH),
            .NUM_OF_VECTOR_REG(NUM_OF_VECTOR_REG),
            .REQ_BUF_DEPTH    (REQ_BUF_DEPTH)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .req     (reg_req[g]),
            .grant   (reg_req_grant[g]),
            .rsp_vld (reg_rsp_vld[g]),
            .rsp_data(reg_rsp_data[g])
        );
    end

endmodule

// File: tb/tb_vreg_responder.sv
// Self-checking bench for vreg_responder: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_vreg_responder;
    import vreg_responder_pkg::*;

    localparam int NL    = 4;
    localparam int W     = 64;
    localparam int NR    = 32;
    localparam int DEPTH = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    cntrl_req_t [NL-1:0]        reg_req;
    logic [NL-1:0]              reg_req_grant;
    logic [NL-1:0]              reg_rsp_vld;
    logic [NL-1:0][W-1:0]       reg_rsp_data;

    vreg_responder #(
        .NUM_OF_LANES     (NL),
        .VECTOR_REG_WIDTH (W),
        .NUM_OF_VECTOR_REG(NR),
        .REQ_BUF_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reg_req      (reg_req),
        .reg_req_grant(reg_req_grant),
        .reg_rsp_vld  (reg_rsp_vld),
        .reg_rsp_data (reg_rsp_data)
    );

    always #5 clk = ~clk;

    // Reference model: pending requests per lane, register contents, and the
    // response each lane should be showing.
    typedef struct {
        bit           we;
        bit [4:0]     addr;
        bit [W-1:0]   data;
    } ent_t;

    ent_t         q [NL][$];
    bit [W-1:0]   mem [NL][NR];
    bit           exp_vld [NL];
    bit [W-1:0]   exp_data [NL];
    bit           last_acc [NL];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < NL; i++) reg_req[i] = '0;
    endtask

    // One clock: decide acceptance from the model, advance the model at the
    // edge, then compare every lane on the falling edge.
    task automatic tick();
        bit acc [NL];
        for (int i = 0; i < NL; i++) begin
            acc[i]      = !reset && reg_req[i].vld && (q[i].size() < DEPTH);
            last_acc[i] = acc[i];
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NL; i++) begin
                q[i].delete();
                exp_vld[i]  = 1'b0;
                exp_data[i] = '0;
                for (int r = 0; r < NR; r++) mem[i][r] = '0;
            end
        end else begin
            for (int i = 0; i < NL; i++) begin
                exp_vld[i] = 1'b0;
                if (q[i].size() > 0) begin
                    ent_t h;
                    h = q[i].pop_front();
                    if (h.we) mem[i][h.addr] = h.data;
                    else begin
                        exp_vld[i]  = 1'b1;
                        exp_data[i] = mem[i][h.addr];
                    end
                end
                if (acc[i]) begin
                    ent_t e;
                    e.we   = reg_req[i].we;
                    e.addr = reg_req[i].addr;
                    e.data = reg_req[i].data;
                    q[i].push_back(e);
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("grant[%0d]", i), W'(reg_req_grant[i]), W'(q[i].size() < DEPTH));
            chk($sformatf("rsp_vld[%0d]", i), W'(reg_rsp_vld[i]), W'(exp_vld[i]));
            chk($sformatf("rsp_data[%0d]", i), reg_rsp_data[i], exp_data[i]);
        end
    endtask

    // Present a request on one lane and hold it until accepted.
    task automatic issue(input int ln, input bit we, input bit [4:0] a, input bit [W-1:0] d);
        int tries = 0;
        reg_req[ln].vld  = 1'b1;
        reg_req[ln].we   = we;
        reg_req[ln].addr = a;
        reg_req[ln].data = d;
        tick();
        while (!last_acc[ln] && tries < 8) begin
            tick();
            tries++;
        end
        if (!last_acc[ln]) chk("accept_timeout", 0, 1);
        reg_req[ln].vld = 1'b0;
    endtask

    initial begin
        idle_all();
        reset = 1'b1;
        @(negedge clk);

        // Reset with every lane asserting vld: nothing may be accepted.
        for (int i = 0; i < NL; i++) begin
            reg_req[i].vld  = 1'b1;
            reg_req[i].we   = 1'b1;
            reg_req[i].addr = 5'd3;
            reg_req[i].data = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        tick();
        tick();
        reset = 1'b0;
        idle_all();
        chk("reset_grant", W'(reg_req_grant), W'(4'hF));
        chk("reset_vld", W'(reg_rsp_vld), 0);
        chk("reset_data0", reg_rsp_data[0], 0);
        for (int c = 0; c < 4; c++) tick();

        // Write then read on lane 0.
        issue(0, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001);
        issue(0, 1'b0, 5'd5, 64'h0);
        tick();
        chk("wr_rd_lane0", reg_rsp_data[0], 64'hDEAD_BEEF_0000_0001);
        for (int c = 0; c < 3; c++) tick();

        // Lane 1 with vld continuously held; ordering checked by the model.
        for (int k = 0; k < 10; k++)
            issue(1, (k % 3) != 2, 5'(k % 4), 64'(k * 17 + 1));
        for (int c = 0; c < 3; c++) tick();

        // Lane 2: fill every register, then stream reads back to back.
        for (int a = 0; a < NR; a++) issue(2, 1'b1, 5'(a), 64'(a));
        for (int a = 0; a < NR; a++) issue(2, 1'b0, 5'(a), 64'h0);
        for (int c = 0; c < 3; c++) tick();

        // All lanes hit address 7 in the same cycles.
        for (int i = 0; i < NL; i++) begin
            reg_req[i].vld  = 1'b1;
            reg_req[i].we   = 1'b1;
            reg_req[i].addr = 5'd7;
            reg_req[i].data = 64'(i);
        end
        tick();
        for (int i = 0; i < NL; i++) reg_req[i].we = 1'b0;
        tick();
        idle_all();
        tick();
        chk("indep_vld_all", W'(reg_rsp_vld), W'(4'hF));
        chk("indep_lane3", reg_rsp_data[3], 64'd3);
        for (int c = 0; c < 2; c++) tick();

        // Reset while a read is in flight on lane 3.
        issue(3, 1'b0, 5'd7, 64'h0);
        reg_req[3].vld = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_all();
        for (int c = 0; c < 3; c++) tick();
        issue(3, 1'b0, 5'd7, 64'h0);
        tick();
        chk("post_reset_rd_vld", W'(reg_rsp_vld[3]), 1);
        chk("post_reset_rd_data", reg_rsp_data[3], 0);
        for (int c = 0; c < 2; c++) tick();

        // Random traffic on all lanes with occasional reset.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NL; i++) begin
                reg_req[i].vld  = ($urandom_range(0, 3) != 0);
                reg_req[i].we   = $urandom_range(0, 1);
                reg_req[i].addr = 5'($urandom_range(0, 7));
                reg_req[i].data = {$urandom, $urandom};
            end
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;
        idle_all();
        for (int c = 0; c < 4; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
